// File: rtl/pc_stack_counter_pkg.sv
// Shared encodings for the SAP program counter with return stack.
// Condition codes are only consumed when PC_COND_EN is defined.
package p_counter_pkg;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_Z      = 2'd1;
  localparam logic [1:0] COND_C      = 2'd2;
  localparam logic [1:0] COND_NZ     = 2'd3;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_JUMP,
    ACT_CALL,
    ACT_RET
  } pc_action_t;

endpackage

// File: rtl/pc_stack_counter_if.sv
// Controller/bus bundle for pc_stack_counter.
// Condition inputs exist only when PC_COND_EN is defined.
interface pc_stack_counter_if #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              pc_inc;
  logic              jump;
  logic              call;
  logic              ret;
  logic              pc_out;
  logic [ADDR_W-1:0] bus_in;
  logic [ADDR_W-1:0] bus_out;
  logic [ADDR_W-1:0] q;
  logic [SP_W-1:0]   sp;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;
`ifdef PC_COND_EN
  logic [1:0]        cond_sel;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output pc_inc, jump, call, ret, pc_out, bus_in,
    output cond_sel, flag_z, flag_c,
    input  bus_out, q, sp, stk_full, stk_empty, stk_err
  );
  modport slave (
    input  pc_inc, jump, call, ret, pc_out, bus_in,
    input  cond_sel, flag_z, flag_c,
    output bus_out, q, sp, stk_full, stk_empty, stk_err
  );
`else
  modport master (
    output pc_inc, jump, call, ret, pc_out, bus_in,
    input  bus_out, q, sp, stk_full, stk_empty, stk_err
  );
  modport slave (
    input  pc_inc, jump, call, ret, pc_out, bus_in,
    output bus_out, q, sp, stk_full, stk_empty, stk_err
  );
`endif

endinterface

// File: rtl/pc_stack_counter_ret_stack.sv
// Return-address LIFO; push-when-full and pop-when-empty are ignored.
module pc_ret_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  localparam int SP_W  = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  logic [W-1:0]    mem [2**IDX_W];
  logic [SP_W-1:0] cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (cnt == SP_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign sp     = cnt;
  assign wr_idx = IDX_W'(cnt);
  assign rd_idx = IDX_W'(cnt - 1'b1);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (pop && !empty)
      cnt <= cnt - 1'b1;
    else if (push && !full)
      cnt <= cnt + 1'b1;
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (push && !full && !reset)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with wrap address and hardware call/return stack.
// Define PC_COND_EN to qualify jump with cond_sel/flag_z/flag_c.
module pc_stack_counter
  import p_counter_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int LAST_ADDR   = 2**ADDR_W - 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  pc_stack_counter_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  logic [ADDR_W-1:0] q_r;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] top;
  logic [SP_W-1:0]   sp;
  logic              full;
  logic              empty;
  logic              err_r;
  logic              jump_ok;
  logic              push;
  logic              pop;
  pc_action_t        act;

  assign nxt = (q_r == LAST) ? '0 : q_r + 1'b1;
  assign tgt = (bus.bus_in > LAST) ? '0 : bus.bus_in;

`ifdef PC_COND_EN
  always_comb begin
    jump_ok = 1'b0;
    unique case (bus.cond_sel)
      COND_ALWAYS: jump_ok = bus.jump;
      COND_Z:      jump_ok = bus.jump & bus.flag_z;
      COND_C:      jump_ok = bus.jump & bus.flag_c;
      COND_NZ:     jump_ok = bus.jump & ~bus.flag_z;
      default:     jump_ok = 1'b0;
    endcase
  end
`else
  assign jump_ok = bus.jump;
`endif

  always_comb begin
    act = ACT_HOLD;
    if (reset)         act = ACT_HOLD;
    else if (bus.ret)  act = ACT_RET;
    else if (bus.call) act = ACT_CALL;
    else if (jump_ok)  act = ACT_JUMP;
    else if (bus.pc_inc) act = ACT_INC;
  end

  assign push = (act == ACT_CALL) && !full;
  assign pop  = (act == ACT_RET) && !empty;

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (nxt),
    .dout  (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      unique case (act)
        ACT_INC:  q_r <= nxt;
        ACT_JUMP: q_r <= tgt;
        ACT_CALL: begin
          if (!full) q_r   <= tgt;
          else       err_r <= 1'b1;
        end
        ACT_RET: begin
          if (!empty) q_r   <= top;
          else        err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.q         = q_r;
  assign bus.bus_out   = bus.pc_out ? q_r : '0;
  assign bus.sp        = sp;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err_r;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed bench: small-wrap instance (a) and default instance (b).
module tb_pc_stack_counter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  pc_stack_counter_if #(.ADDR_W(4), .STACK_DEPTH(4)) ia ();
  pc_stack_counter_if #(.ADDR_W(4), .STACK_DEPTH(4)) ib ();

  pc_stack_counter #(.ADDR_W(4), .LAST_ADDR(2), .STACK_DEPTH(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ia.slave)
  );

  pc_stack_counter #(.ADDR_W(4), .STACK_DEPTH(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op_b(input logic inc, input logic jmp, input logic cal,
                      input logic rt, input logic [3:0] bin);
    ib.pc_inc = inc;
    ib.jump   = jmp;
    ib.call   = cal;
    ib.ret    = rt;
    ib.bus_in = bin;
    tick();
    ib.pc_inc = 1'b0;
    ib.jump   = 1'b0;
    ib.call   = 1'b0;
    ib.ret    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    ia.pc_inc = 0; ia.jump = 0; ia.call = 0; ia.ret = 0;
    ia.pc_out = 0; ia.bus_in = '0;
    ib.pc_inc = 0; ib.jump = 0; ib.call = 0; ib.ret = 0;
    ib.pc_out = 0; ib.bus_in = '0;
`ifdef PC_COND_EN
    ia.cond_sel = 2'd0; ia.flag_z = 0; ia.flag_c = 0;
    ib.cond_sel = 2'd0; ib.flag_z = 0; ib.flag_c = 0;
`endif
    #1;
    do_reset();

    chk("rst_q",     32'(ia.q), 0);
    chk("rst_sp",    32'(ia.sp), 0);
    chk("rst_empty", 32'(ia.stk_empty), 1);
    chk("rst_full",  32'(ia.stk_full), 0);
    chk("rst_err",   32'(ia.stk_err), 0);
    chk("rst_q_b",   32'(ib.q), 0);

    // wrap at LAST_ADDR=2
    ia.pc_inc = 1'b1;
    tick(); chk("inc1", 32'(ia.q), 1);
    tick(); chk("inc2", 32'(ia.q), 2);
    tick(); chk("inc_wrap", 32'(ia.q), 0);
    ia.pc_inc = 1'b0;
    chk("a_empty", 32'(ia.stk_empty), 1);

    ia.jump = 1'b1; ia.bus_in = 4'd7;
    tick(); chk("jump_clamp", 32'(ia.q), 0);
    ia.bus_in = 4'd2;
    tick(); chk("jump_a", 32'(ia.q), 2);
    ia.jump = 1'b0;
    #1 chk("bus_out_off", 32'(ia.bus_out), 0);
    ia.pc_out = 1'b1;
    #1 chk("bus_out_on", 32'(ia.bus_out), 2);
    ia.pc_out = 1'b0;

    // single call/return
    op_b(0, 1, 0, 0, 4'd5); chk("jump5", 32'(ib.q), 5);
    op_b(0, 0, 1, 0, 4'd9);
    chk("call_q",  32'(ib.q), 9);
    chk("call_sp", 32'(ib.sp), 1);
    op_b(0, 0, 0, 1, 4'd0);
    chk("ret_q",   32'(ib.q), 6);
    chk("ret_sp",  32'(ib.sp), 0);
    chk("ret_err", 32'(ib.stk_err), 0);

    // nested calls to overflow
    op_b(0, 0, 1, 0, 4'd10); chk("n1_q", 32'(ib.q), 10);
    op_b(0, 0, 1, 0, 4'd11); chk("n2_q", 32'(ib.q), 11);
    op_b(0, 0, 1, 0, 4'd12); chk("n3_q", 32'(ib.q), 12);
    op_b(0, 0, 1, 0, 4'd13);
    chk("n4_q",    32'(ib.q), 13);
    chk("n4_full", 32'(ib.stk_full), 1);
    chk("n4_err",  32'(ib.stk_err), 0);
    op_b(0, 0, 1, 0, 4'd14);
    chk("ovf_q",    32'(ib.q), 13);
    chk("ovf_sp",   32'(ib.sp), 4);
    chk("ovf_full", 32'(ib.stk_full), 1);
    chk("ovf_err",  32'(ib.stk_err), 1);
    op_b(0, 0, 0, 1, 4'd0); chk("u1_q", 32'(ib.q), 13);
    op_b(0, 0, 0, 1, 4'd0); chk("u2_q", 32'(ib.q), 12);
    op_b(0, 0, 0, 1, 4'd0); chk("u3_q", 32'(ib.q), 11);
    op_b(0, 0, 0, 1, 4'd0);
    chk("u4_q",     32'(ib.q), 7);
    chk("u4_empty", 32'(ib.stk_empty), 1);

    // underflow and jump-over-inc priority
    do_reset();
    chk("rst2_err", 32'(ib.stk_err), 0);
    op_b(0, 1, 0, 0, 4'd5);
    op_b(0, 0, 0, 1, 4'd0);
    chk("unf_q",   32'(ib.q), 5);
    chk("unf_err", 32'(ib.stk_err), 1);
    op_b(1, 1, 0, 0, 4'd3); chk("jmp_pri", 32'(ib.q), 3);

    // wrap at default LAST_ADDR=15
    op_b(0, 1, 0, 0, 4'd15);
    op_b(1, 0, 0, 0, 4'd0); chk("wrap15", 32'(ib.q), 0);

    // call+ret together, then reset mid-call
    do_reset();
    op_b(0, 1, 0, 0, 4'd3);
    op_b(0, 0, 1, 0, 4'd8);
    chk("c8_q", 32'(ib.q), 8);
    op_b(0, 0, 1, 1, 4'd12);
    chk("cr_q",   32'(ib.q), 4);
    chk("cr_sp",  32'(ib.sp), 0);
    chk("cr_err", 32'(ib.stk_err), 0);
    op_b(0, 0, 1, 0, 4'd9);
    chk("c9_sp", 32'(ib.sp), 1);
    ib.call = 1'b1; ib.bus_in = 4'd2;
    do_reset();
    ib.call = 1'b0;
    chk("mid_rst_q",   32'(ib.q), 0);
    chk("mid_rst_sp",  32'(ib.sp), 0);
    chk("mid_rst_err", 32'(ib.stk_err), 0);

`ifdef PC_COND_EN
    op_b(0, 1, 0, 0, 4'd4);
    ib.cond_sel = 2'd1; ib.flag_z = 1'b0;
    op_b(1, 1, 0, 0, 4'd9); chk("cond_nz_fall", 32'(ib.q), 5);
    ib.flag_z = 1'b1;
    op_b(1, 1, 0, 0, 4'd9); chk("cond_z_take", 32'(ib.q), 9);
    ib.cond_sel = 2'd3;
    op_b(1, 1, 0, 0, 4'd2); chk("cond_nzsel", 32'(ib.q), 10);
    ib.cond_sel = 2'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
